// File: rtl/jump_charge_ctl.sv
`default_nettype none
// ============================================================================
// jump_charge_ctl : ground walk, charged-jump sequencer and landing guard
// Rev 1.0
// ============================================================================
module jump_charge_ctl #(
   parameter int TICK_DIV   = 100000,
   parameter int POWER_W    = 6,
   parameter int CHARGE_MAX = 63,
   parameter int MIN_POWER  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_space,
   input  logic               key_left,
   input  logic               key_right,
   input  logic               on_ground,
   input  logic               jump_ack,
   output logic               jump_req,
   output logic [POWER_W-1:0] jump_power,
   output logic [1:0]         jump_dir,
   output logic               walk_left,
   output logic               walk_right,
   output logic               charging,
   output logic [POWER_W-1:0] charge_level,
   output logic [1:0]         state_dbg
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0]  c_tick_last    = TICK_W'(TICK_DIV - 1);
   localparam logic [POWER_W-1:0] c_charge_max   = POWER_W'(CHARGE_MAX);
   localparam logic [POWER_W-1:0] c_min_power    = POWER_W'(MIN_POWER);
   localparam logic [POWER_W:0]   c_charge_max_x = (POWER_W + 1)'(CHARGE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHARGE = 2'd1,
      ST_LAUNCH = 2'd2,
      ST_AIR    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                space_prev_q, space_prev_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [POWER_W-1:0]  charge_level_q, charge_level_d;
   logic [POWER_W-1:0]  jump_power_q, jump_power_d;
   logic [1:0]          jump_dir_q, jump_dir_d;
   logic                jump_req_q, jump_req_d;
   logic                walk_left_q, walk_left_d;
   logic                walk_right_q, walk_right_d;
   logic                charging_q, charging_d;
   logic                air_seen_q, air_seen_d;

   logic                w_left_only;
   logic                w_right_only;
   logic [1:0]          w_key_dir;
   logic                w_space_rise;
   logic                w_tick_wrap;
   logic [POWER_W:0]    w_charge_inc;
   logic [POWER_W-1:0]  w_floored_power;

   assign w_left_only     = key_left & ~key_right;
   assign w_right_only    = key_right & ~key_left;
   assign w_key_dir       = {w_right_only, w_left_only};
   assign w_space_rise    = key_space & ~space_prev_q;
   assign w_tick_wrap     = (tick_q == c_tick_last);
   assign w_charge_inc    = {1'b0, charge_level_q} + 1'b1;
   assign w_floored_power = (charge_level_q < c_min_power) ? c_min_power : charge_level_q;

   always_comb begin
      state_d        = state_q;
      space_prev_d   = key_space;
      tick_d         = tick_q;
      charge_level_d = charge_level_q;
      jump_power_d   = jump_power_q;
      jump_dir_d     = jump_dir_q;
      jump_req_d     = jump_req_q;
      walk_left_d    = 1'b0;
      walk_right_d   = 1'b0;
      air_seen_d     = air_seen_q;

      case (state_q)
         ST_IDLE: begin
            walk_left_d  = w_left_only & on_ground;
            walk_right_d = w_right_only & on_ground;
            if (w_space_rise && on_ground) begin
               state_d        = ST_CHARGE;
               charge_level_d = '0;
               tick_d         = '0;
               walk_left_d    = 1'b0;
               walk_right_d   = 1'b0;
            end
         end

         ST_CHARGE: begin
            tick_d = w_tick_wrap ? '0 : tick_q + 1'b1;
            if (w_tick_wrap) begin
               charge_level_d = w_charge_inc[POWER_W-1:0];
            end
            if (!on_ground) begin
               state_d        = ST_AIR;
               charge_level_d = '0;
               air_seen_d     = 1'b1;
            end else if (!key_space) begin
               // Release uses the level reached so far; this cycle's tick is dropped.
               state_d        = ST_LAUNCH;
               tick_d         = '0;
               charge_level_d = charge_level_q;
               jump_power_d   = w_floored_power;
               jump_dir_d     = w_key_dir;
               jump_req_d     = 1'b1;
            end else if (w_tick_wrap && (w_charge_inc >= c_charge_max_x)) begin
               state_d        = ST_LAUNCH;
               tick_d         = '0;
               charge_level_d = c_charge_max;
               jump_power_d   = c_charge_max;
               jump_dir_d     = w_key_dir;
               jump_req_d     = 1'b1;
            end
         end

         ST_LAUNCH: begin
            if (jump_ack) begin
               state_d        = ST_AIR;
               jump_req_d     = 1'b0;
               charge_level_d = '0;
               air_seen_d     = 1'b0;
            end
         end

         ST_AIR: begin
            // Landing only counts once physics has reported leaving the ground.
            if (!on_ground) begin
               air_seen_d = 1'b1;
            end else if (air_seen_q) begin
               state_d    = ST_IDLE;
               air_seen_d = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      charging_d = (state_d == ST_CHARGE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         space_prev_q   <= 1'b1;
         tick_q         <= '0;
         charge_level_q <= '0;
         jump_power_q   <= '0;
         jump_dir_q     <= 2'b00;
         jump_req_q     <= 1'b0;
         walk_left_q    <= 1'b0;
         walk_right_q   <= 1'b0;
         charging_q     <= 1'b0;
         air_seen_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         space_prev_q   <= space_prev_d;
         tick_q         <= tick_d;
         charge_level_q <= charge_level_d;
         jump_power_q   <= jump_power_d;
         jump_dir_q     <= jump_dir_d;
         jump_req_q     <= jump_req_d;
         walk_left_q    <= walk_left_d;
         walk_right_q   <= walk_right_d;
         charging_q     <= charging_d;
         air_seen_q     <= air_seen_d;
      end
   end

   assign jump_req     = jump_req_q;
   assign jump_power   = jump_power_q;
   assign jump_dir     = jump_dir_q;
   assign walk_left    = walk_left_q;
   assign walk_right   = walk_right_q;
   assign charging     = charging_q;
   assign charge_level = charge_level_q;
   assign state_dbg    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_jump_charge_ctl.sv
`default_nettype none
// ============================================================================
// tb_jump_charge_ctl : table, directed and randomized checks of jump_charge_ctl
// Rev 1.0
// ============================================================================
module tb_jump_charge_ctl;

   localparam int TD   = 4;
   localparam int PW   = 6;
   localparam int CMAX = 7;
   localparam int MINP = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          key_space = 1'b0;
   logic          key_left = 1'b0;
   logic          key_right = 1'b0;
   logic          on_ground = 1'b1;
   logic          jump_ack = 1'b0;
   logic          jump_req;
   logic [PW-1:0] jump_power;
   logic [1:0]    jump_dir;
   logic          walk_left;
   logic          walk_right;
   logic          charging;
   logic [PW-1:0] charge_level;
   logic [1:0]    state_dbg;

   jump_charge_ctl #(
      .TICK_DIV   (TD),
      .POWER_W    (PW),
      .CHARGE_MAX (CMAX),
      .MIN_POWER  (MINP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .key_space    (key_space),
      .key_left     (key_left),
      .key_right    (key_right),
      .on_ground    (on_ground),
      .jump_ack     (jump_ack),
      .jump_req     (jump_req),
      .jump_power   (jump_power),
      .jump_dir     (jump_dir),
      .walk_left    (walk_left),
      .walk_right   (walk_right),
      .charging     (charging),
      .charge_level (charge_level),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: phase plus a count of held-charge cycles; level = count / TD.
   int m_mode, m_n, e_req, e_pw, e_dir, e_wl, e_wr, e_chg, e_lvl;
   bit m_prev, m_seen;

   function automatic void m_reset();
      m_mode = 0; m_n = 0; m_prev = 1'b1; m_seen = 1'b0;
      e_req = 0; e_pw = 0; e_dir = 0; e_wl = 0; e_wr = 0; e_chg = 0; e_lvl = 0;
   endfunction

   function automatic void m_step();
      bit rise;
      int dir;
      rise = key_space && !m_prev;
      dir  = (key_left && !key_right) ? 1 : ((key_right && !key_left) ? 2 : 0);
      e_wl = 0;
      e_wr = 0;
      case (m_mode)
         0: begin
            if (on_ground) begin
               e_wl = (key_left && !key_right) ? 1 : 0;
               e_wr = (key_right && !key_left) ? 1 : 0;
            end
            if (rise && on_ground) begin
               m_mode = 1; m_n = 0; e_lvl = 0; e_wl = 0; e_wr = 0;
            end
         end
         1: begin
            if (!on_ground) begin
               m_mode = 3; e_lvl = 0; m_seen = 1'b1;
            end else if (!key_space) begin
               m_mode = 2; e_req = 1; e_dir = dir;
               e_lvl  = m_n / TD;
               e_pw   = (e_lvl > MINP) ? e_lvl : MINP;
            end else begin
               m_n = m_n + 1;
               if (m_n >= TD * CMAX) begin
                  m_mode = 2; e_req = 1; e_dir = dir; e_lvl = CMAX; e_pw = CMAX;
               end else begin
                  e_lvl = m_n / TD;
               end
            end
         end
         2: begin
            if (jump_ack) begin
               m_mode = 3; e_req = 0; e_lvl = 0; m_seen = 1'b0;
            end
         end
         default: begin
            if (!on_ground) m_seen = 1'b1;
            else if (m_seen) m_mode = 0;
         end
      endcase
      m_prev = key_space;
      e_chg  = (m_mode == 1) ? 1 : 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".state"},  int'(state_dbg),    m_mode);
      chk({tag, ".req"},    int'(jump_req),     e_req);
      chk({tag, ".power"},  int'(jump_power),   e_pw);
      chk({tag, ".dir"},    int'(jump_dir),     e_dir);
      chk({tag, ".wl"},     int'(walk_left),    e_wl);
      chk({tag, ".wr"},     int'(walk_right),   e_wr);
      chk({tag, ".chg"},    int'(charging),     e_chg);
      chk({tag, ".level"},  int'(charge_level), e_lvl);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      m_step();
      #1;
      chk_model(tag);
   endtask

   task automatic set_in(input bit sp, input bit l, input bit r, input bit g, input bit ack);
      key_space = sp; key_left = l; key_right = r; on_ground = g; jump_ack = ack;
   endtask

   task automatic apply_reset(input bit sp_held);
      set_in(sp_held, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      #1;
      m_reset();
      chk("rst.state", int'(state_dbg), 0);
      chk("rst.req",   int'(jump_req),  0);
      chk("rst.power", int'(jump_power), 0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
   endtask

   typedef struct {
      bit sp, l, r, g, ack;
      int st, req, pw, dir, wl, wr, chg, lvl;
   } vec_t;

   function automatic vec_t mk(input bit sp, input bit l, input bit r, input bit g, input bit ack,
                               input int st, input int req, input int pw, input int dir,
                               input int wl, input int wr, input int chg, input int lvl);
      vec_t v;
      v.sp = sp; v.l = l; v.r = r; v.g = g; v.ack = ack;
      v.st = st; v.req = req; v.pw = pw; v.dir = dir;
      v.wl = wl; v.wr = wr; v.chg = chg; v.lvl = lvl;
      return v;
   endfunction

   vec_t tbl[18];

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      //            sp l r g a   st req pw dir wl wr chg lvl
      tbl[0]  = mk(0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1, 0, 0);
      tbl[1]  = mk(0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1, 0, 0);
      tbl[2]  = mk(0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(0, 1, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 0);
      tbl[4]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      tbl[5]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      tbl[6]  = mk(1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
      tbl[8]  = mk(1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 0);
      tbl[9]  = mk(0, 0, 0, 1, 0,  2, 1, 2, 0, 0, 0, 0, 0);
      tbl[10] = mk(0, 1, 0, 1, 0,  2, 1, 2, 0, 0, 0, 0, 0);
      tbl[11] = mk(0, 1, 0, 1, 1,  3, 0, 2, 0, 0, 0, 0, 0);
      tbl[12] = mk(0, 0, 0, 1, 0,  3, 0, 2, 0, 0, 0, 0, 0);
      tbl[13] = mk(1, 0, 0, 1, 0,  3, 0, 2, 0, 0, 0, 0, 0);
      tbl[14] = mk(1, 0, 0, 0, 0,  3, 0, 2, 0, 0, 0, 0, 0);
      tbl[15] = mk(1, 0, 0, 1, 0,  0, 0, 2, 0, 0, 0, 0, 0);
      tbl[16] = mk(1, 0, 0, 1, 0,  0, 0, 2, 0, 0, 0, 0, 0);
      tbl[17] = mk(0, 0, 1, 1, 0,  0, 0, 2, 0, 0, 1, 0, 0);

      m_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init.state", int'(state_dbg), 0);
      chk("init.req",   int'(jump_req), 0);
      chk("init.power", int'(jump_power), 0);
      chk("init.dir",   int'(jump_dir), 0);
      chk("init.walk",  int'({walk_left, walk_right}), 0);
      chk("init.chg",   int'(charging), 0);
      chk("init.level", int'(charge_level), 0);
      #2;
      rst = 1'b1;

      for (int i = 0; i < 18; i++) begin
         set_in(tbl[i].sp, tbl[i].l, tbl[i].r, tbl[i].g, tbl[i].ack);
         tick($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.state", i), int'(state_dbg), tbl[i].st);
         chk($sformatf("tbl%0d.req", i),   int'(jump_req), tbl[i].req);
         chk($sformatf("tbl%0d.power", i), int'(jump_power), tbl[i].pw);
         chk($sformatf("tbl%0d.dir", i),   int'(jump_dir), tbl[i].dir);
         chk($sformatf("tbl%0d.wl", i),    int'(walk_left), tbl[i].wl);
         chk($sformatf("tbl%0d.wr", i),    int'(walk_right), tbl[i].wr);
         chk($sformatf("tbl%0d.chg", i),   int'(charging), tbl[i].chg);
         chk($sformatf("tbl%0d.level", i), int'(charge_level), tbl[i].lvl);
      end

      // Charged jump: 13 held cycles, release leaning left.
      set_in(1, 0, 0, 1, 0); tick("cj.rise");
      chk("cj.enter", int'(state_dbg), 1);
      repeat (13) tick("cj.hold");
      chk("cj.level", int'(charge_level), 3);
      chk("cj.chg", int'(charging), 1);
      set_in(0, 1, 0, 1, 0); tick("cj.rel");
      chk("cj.req", int'(jump_req), 1);
      chk("cj.power", int'(jump_power), 3);
      chk("cj.dir", int'(jump_dir), 1);
      for (int i = 0; i < 5; i++) begin
         set_in(i[0], 0, 1, 1, 0); tick("cj.wait");
         chk("cj.hold_power", int'(jump_power), 3);
         chk("cj.hold_dir", int'(jump_dir), 1);
      end
      set_in(0, 0, 0, 1, 1); tick("cj.ack");
      chk("cj.ack_req", int'(jump_req), 0);
      chk("cj.ack_state", int'(state_dbg), 3);
      set_in(0, 0, 0, 0, 0); tick("cj.up");
      set_in(0, 0, 0, 1, 0); tick("cj.land");
      chk("cj.land_state", int'(state_dbg), 0);

      // Auto-launch while holding right.
      set_in(1, 0, 1, 1, 0); tick("al.rise");
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         tick("al.hold");
         if (state_dbg == 2'd2) begin
            k = i;
            break;
         end
      end
      chk("al.cycles", k, 28);
      chk("al.power", int'(jump_power), CMAX);
      chk("al.dir", int'(jump_dir), 2);
      chk("al.level", int'(charge_level), CMAX);
      repeat (3) tick("al.launch");
      jump_ack = 1'b1; tick("al.ack"); jump_ack = 1'b0;
      on_ground = 1'b0; tick("al.up");
      on_ground = 1'b1; tick("al.land");
      chk("al.land_state", int'(state_dbg), 0);
      repeat (4) tick("al.held");
      chk("al.no_recharge", int'(state_dbg), 0);

      // Fall-off during charge.
      set_in(0, 0, 0, 1, 0); tick("fo.idle");
      set_in(1, 0, 0, 1, 0); tick("fo.rise");
      repeat (8) tick("fo.hold");
      chk("fo.level", int'(charge_level), 2);
      on_ground = 1'b0; tick("fo.fall");
      chk("fo.state", int'(state_dbg), 3);
      chk("fo.level0", int'(charge_level), 0);
      chk("fo.req", int'(jump_req), 0);
      on_ground = 1'b1; tick("fo.land");
      chk("fo.idle_state", int'(state_dbg), 0);

      // Reset mid-launch with space held through release.
      set_in(0, 0, 0, 1, 0); tick("rs.idle");
      set_in(1, 0, 0, 1, 0); tick("rs.rise");
      set_in(0, 0, 0, 1, 0); tick("rs.launch");
      chk("rs.req_before", int'(jump_req), 1);
      apply_reset(1'b1);
      repeat (3) tick("rs.held");
      chk("rs.no_charge", int'(state_dbg), 0);
      key_space = 1'b0; tick("rs.rel");
      key_space = 1'b1; tick("rs.repress");
      chk("rs.charge", int'(state_dbg), 1);

      // Randomized traffic against the model.
      apply_reset(1'b0);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 20) == 0) key_space = ~key_space;
         key_left  = ($urandom_range(0, 2) == 0);
         key_right = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 9) == 0) on_ground = ~on_ground;
         jump_ack  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 399) == 0) apply_reset($urandom_range(0, 1) == 1);
         tick("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jump_charge_ctl.md
Name: jump_charge_ctl

Overview:
- Player-action sequencer between keyboard_ctl (key_space/key_left/key_right levels) and the draw_rect_ctl physics datapath.
- Handles ground walking, converts a held space key into a charged jump (power grows over time), and issues one jump command per charge to the physics block over a req/ack handshake.
- Then waits for a confirmed landing before it accepts another jump.

Parameters:
TICK_DIV, 100000, clk cycles per charge increment (1 ms at 100 MHz)
POWER_W, 6, width of charge_level/jump_power
CHARGE_MAX, 63, saturation value; reaching it forces an automatic launch
MIN_POWER, 4, floor applied to jump_power on a short tap

Ports:
clk  in  1  system clock (same domain as keyboard_ctl outputs)
rst  in  1  asynchronous reset, active-low (rst=0 resets)
key_space  in  1  space level, synchronous to clk
key_left  in  1  left arrow level
key_right  in  1  right arrow level
on_ground  in  1  from physics: player standing on a surface
jump_ack  in  1  physics accepted the jump command
jump_req  out  1  jump command valid
jump_power  out  POWER_W  latched jump strength
jump_dir  out  2  00 vertical, 01 left, 10 right
walk_left  out  1  ground walk left request
walk_right  out  1  ground walk right request
charging  out  1  high while in CHARGE
charge_level  out  POWER_W  current charge (for HUD bar)
state_dbg  out  2  IDLE=0, CHARGE=1, LAUNCH=2, AIR=3

Behaviour:
- Reset (rst=0, async):
  - State IDLE; all outputs 0; tick counter 0; air_seen 0.
  - space_prev is set to 1, so a space key held through reset release does not start a charge.
- All outputs are registered. Edge detect: space_rise = key_space & ~space_prev; space_prev <= key_space every cycle.
- IDLE:
  - walk_left <= key_left & ~key_right & on_ground; walk_right is the mirror. Both keys or neither gives both 0.
  - space_rise & on_ground goes to CHARGE next edge; charge_level <= 0, tick <= 0, walks <= 0.
  - space_rise with on_ground=0 is ignored.
- CHARGE:
  - Walks are 0. tick increments each cycle; when tick==TICK_DIV-1 it wraps to 0 and charge_level increments.
  - Priority 1, on_ground=0: go to AIR, charge_level <= 0, no jump issued (air_seen <= 1).
  - Priority 2, key_space=0: go to LAUNCH. jump_power <= max(charge_level, MIN_POWER), using the current value; any tick that cycle is discarded. jump_dir is sampled from the keys that cycle using the same exclusivity rule (both or neither gives 00).
  - Priority 3, tick wrap that would make charge_level==CHARGE_MAX: charge_level <= CHARGE_MAX, jump_power <= CHARGE_MAX, jump_dir sampled, go to LAUNCH (auto-jump).
- LAUNCH:
  - jump_req=1 with jump_power and jump_dir held stable.
  - On the edge where jump_ack=1: go to AIR, jump_req <= 0, charge_level <= 0, air_seen <= 0.
  - jump_ack while not in LAUNCH is ignored. Key changes during LAUNCH are ignored.
- AIR:
  - air_seen <= 1 when on_ground=0.
  - Go to IDLE on the first cycle with on_ground=1 & air_seen=1. This blocks a false landing while physics has not yet left the ground.
  - Space held across the landing needs a fresh rise to charge again.
- Arithmetic:
  - tick is ceil(log2(TICK_DIV)) bits, unsigned.
  - charge_level saturates and never wraps; require CHARGE_MAX < 2^POWER_W and MIN_POWER <= CHARGE_MAX.
- Reset mid-operation (any state): outputs drop immediately, no ack is required, and the FSM restarts in IDLE.

Test Plan (TICK_DIV=4, CHARGE_MAX=7, MIN_POWER=2, POWER_W=6):
- Walking: on_ground=1, key_right=1 for 10 cycles -> walk_right=1 from the 2nd edge, walk_left=0. Add key_left=1 -> both walks 0 one cycle later.
- Charged jump:
  - Space rise, held 13 cycles in CHARGE -> charge_level=3, charging=1.
  - Release with key_left=1 -> jump_req=1, jump_power=3, jump_dir=01.
  - jump_ack after 5 cycles -> jump_req=0 next edge, state_dbg=3.
  - on_ground 1->0->1 -> IDLE.
- Tap: space high 1 cycle, no arrows -> jump_power=2 (MIN_POWER), jump_dir=00. on_ground kept 1 after ack -> stays AIR until on_ground goes 0 then 1.
- Auto-launch: space held 40 cycles with key_right=1 -> LAUNCH after 28 CHARGE cycles, jump_power=7, jump_dir=10. After landing with space still held -> IDLE, no new charge.
- Fall-off: on_ground=0 at charge_level=2 -> AIR, charge_level=0, jump_req never asserted. on_ground=1 -> IDLE.
- Reset:
  - rst=0 mid-LAUNCH -> jump_req=0 asynchronously, state_dbg=0.
  - rst released with key_space=1 held -> no CHARGE until space is released and pressed again.
